easyaxi_slv_rd: RTL and testbench
=================================

Name: easyaxi_slv_rd

Overview:
Parametrised AXI read-path slave, successor to the single-entry AR-only slave.
- Accepts AR requests into a DEPTH-entry in-order outstanding buffer.
- Decodes each address against a configurable window.
- Returns one single-beat R response per request after a programmable latency: OKAY for a hit, DECERR for a miss.
- Sits behind the EasyAXI master/interconnect as the reference read target for bring-up and outstanding-transaction tests.

Parameters:
ID_W, 4, AR/R ID width
ADDR_W, 32, address width
DATA_W, 32, read-data width
DEPTH, 4, outstanding buffer entries; power of 2, >=2
BASE_ADDR, 32'h0000_0000, decode window base
ADDR_SPAN, 32'h0000_1000, decode window size in bytes; >0
RD_LAT, 2, cycles from head-of-buffer to rvalid; >=1

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
enable  in  1  accept new AR requests when high
axi_slv_arvalid  in  1  AR valid
axi_slv_arready  out  1  AR ready
axi_slv_arid  in  ID_W  AR ID
axi_slv_araddr  in  ADDR_W  AR address
axi_slv_rvalid  out  1  R valid
axi_slv_rready  in  1  R ready
axi_slv_rid  out  ID_W  R ID
axi_slv_rdata  out  DATA_W  R data
axi_slv_rresp  out  2  R response
axi_slv_rlast  out  1  R last

Behaviour:
Interface:
- One clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: buffer empty, count=0, FSM IDLE, latency counter 0, arready=0, rvalid=0, rid/rdata/rresp=0, rlast=0.

AR handshake and buffer push:
- arready = enable & ~full; combinational from registered state only.
- Handshake = arvalid & arready. It pushes {arid, araddr, miss} at the clock edge.
- miss = ~(araddr >= BASE_ADDR && araddr < BASE_ADDR+ADDR_SPAN). Compute the comparison at ADDR_W+1 bits so BASE_ADDR+ADDR_SPAN cannot wrap.
- A miss does NOT stall AR. It is accepted and answered with DECERR.
- Buffer is FIFO, in order. Pointers are log2(DEPTH) bits and wrap modulo DEPTH.
- count is log2(DEPTH)+1 bits. full = (count==DEPTH); empty = (count==0).
- Push and pop in the same cycle: count unchanged, both pointers advance.
- No bypass: a full buffer blocks AR even if a pop happens that cycle. arready re-asserts the cycle after the pop.

R response FSM:
- IDLE: if ~empty, go to WAIT and load lat_cnt = RD_LAT-1.
- WAIT: if lat_cnt==0 go to RESP, else lat_cnt--.
- RESP: rvalid=1; rid = head id; rlast=1.
  - Hit: rdata = head addr, zero-extended or truncated to DATA_W; rresp = 2'b00.
  - Miss: rdata = 0; rresp = 2'b11.
- In RESP, on rvalid & rready: pop head. Go to WAIT (reload RD_LAT-1) if count>1 before the pop, else IDLE.
- R outputs are registered and held stable while rvalid & ~rready. rvalid never drops without a handshake. Outputs return to 0 when rvalid=0.

Latency:
- AR accepted at edge T into an empty, IDLE block: rvalid rises at edge T+1+RD_LAT.
- Back-to-back responses are spaced RD_LAT+1 cycles, plus any rready stall.

Boundary cases:
- enable low mid-traffic: arready=0 immediately; buffered entries still drain normally.
- Address exactly BASE_ADDR+ADDR_SPAN-1 is a hit. Exactly BASE_ADDR+ADDR_SPAN is a miss.
- Reset mid-operation: all outstanding entries are discarded and outputs go to reset values asynchronously.

Decomposition:
- Shared package easyaxi_pkg:
  - default width constants (ID_W, ADDR_W, DATA_W)
  - RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
  - FSM state encoding (IDLE, WAIT, RESP)
- One natural sub-module: easyaxi_sync_fifo (params WIDTH, DEPTH).
  - Ports: push, pop, wdata, rdata, full, empty, count.
  - Instantiated once with WIDTH = ID_W+ADDR_W+1.

Test Plan:
1. Single hit: enable=1; AR id=3 addr=0x0000_0010; rready=1 -> rvalid exactly 3 cycles after the AR edge (RD_LAT=2); rid=3, rdata=0x10, rresp=00, rlast=1.
2. Decode miss: AR id=5 addr=0x0000_1000 -> accepted without stall; R id=5, rdata=0, rresp=11.
3. Fill and full: 5 back-to-back ARs (ids 0-4) with rready=0 -> first 4 accepted, arready=0 while holding id 4. Raise rready -> arready returns the cycle after the first pop; R order is ids 0,1,2,3,4.
4. R backpressure: rready=0 for 6 cycles during RESP -> rid, rdata and rresp stay constant and rvalid stays 1; pop occurs only on the handshake cycle.
5. enable toggle: enable=0 with 2 entries buffered and arvalid=1 -> arready=0, both responses still delivered. enable=1 -> the pending AR is accepted the same cycle.
6. Reset mid-flight: assert rst_n=0 while in RESP with 3 entries -> rvalid=0 and arready=0 immediately. After release: empty, IDLE, and the first new AR follows case 1 timing.

Source files
------------

// File: rtl/easyaxi_slv_rd_pkg.sv
// Shared EasyAXI definitions: default widths, response codes, read FSM states.
package easyaxi_pkg;

  localparam int AXI_ID_W   = 4;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } rd_state_e;

endpackage

// File: rtl/easyaxi_slv_rd_if.sv
// AXI read-path (AR + R) bundle between a master and the read slave.
interface easyaxi_slv_rd_if
  import easyaxi_pkg::*;
#(
  parameter int ID_W   = AXI_ID_W,
  parameter int ADDR_W = AXI_ADDR_W,
  parameter int DATA_W = AXI_DATA_W
);
  logic              arvalid;
  logic              arready;
  logic [ID_W-1:0]   arid;
  logic [ADDR_W-1:0] araddr;
  logic              rvalid;
  logic              rready;
  logic [ID_W-1:0]   rid;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output arvalid, arid, araddr, rready,
    input  arready, rvalid, rid, rdata, rresp, rlast
  );

  modport slave (
    input  arvalid, arid, araddr, rready,
    output arready, rvalid, rid, rdata, rresp, rlast
  );
endinterface

// File: rtl/easyaxi_slv_rd_sync_fifo.sv
// In-order synchronous FIFO with occupancy count; head is visible combinationally.
module easyaxi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr, rptr;
  logic [PW:0]      cnt;
  logic             do_push, do_pop;

  // Overflow/underflow requests are dropped so pointers can never cross.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  assign full  = (cnt == (PW+1)'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;
  assign rdata = mem[rptr];

  // Pointer and occupancy bookkeeping; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: entries are only read once written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/easyaxi_slv_rd.sv
// AXI read slave: buffers AR requests in order, decodes against one address
// window and answers each with a single-beat R after a fixed latency.
module easyaxi_slv_rd
  import easyaxi_pkg::*;
#(
  parameter int              ID_W      = AXI_ID_W,
  parameter int              ADDR_W    = AXI_ADDR_W,
  parameter int              DATA_W    = AXI_DATA_W,
  parameter int              DEPTH     = 4,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
  parameter logic [ADDR_W-1:0] ADDR_SPAN = 32'h0000_1000,
  parameter int              RD_LAT    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  easyaxi_slv_rd_if.slave  axi_slv
);
  localparam int PW = $clog2(DEPTH);
  localparam int EW = ID_W + ADDR_W + 1;
  localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LW-1:0] LAT_INIT = LW'(RD_LAT - 1);

  // Window bounds one bit wider than the address so BASE+SPAN cannot wrap.
  localparam logic [ADDR_W:0] WIN_LO = {1'b0, BASE_ADDR};
  localparam logic [ADDR_W:0] WIN_HI = {1'b0, BASE_ADDR} + {1'b0, ADDR_SPAN};

  rd_state_e         state, state_d;
  logic [LW-1:0]     lat_cnt, lat_d;
  logic              alive;
  logic              arready, ar_hs, ar_miss, pop;
  logic [ADDR_W:0]   araddr_x;
  logic [EW-1:0]     fifo_wd, fifo_rd;
  logic              fifo_full, fifo_empty;
  logic [PW:0]       fifo_count;
  logic [ID_W-1:0]   head_id;
  logic [ADDR_W-1:0] head_addr;
  logic              head_miss;
  logic [DATA_W-1:0] hit_data;

  logic              rvalid_q, rvalid_d;
  logic [ID_W-1:0]   rid_q, rid_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;
  logic              rlast_q, rlast_d;

  // AR side: ready depends only on registered state; misses are still accepted.
  assign arready  = alive & enable & ~fifo_full;
  assign ar_hs    = axi_slv.arvalid & arready;
  assign araddr_x = {1'b0, axi_slv.araddr};
  assign ar_miss  = ~((araddr_x >= WIN_LO) && (araddr_x < WIN_HI));
  assign fifo_wd  = {axi_slv.arid, axi_slv.araddr, ar_miss};

  easyaxi_sync_fifo #(.WIDTH(EW), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (ar_hs),
    .pop   (pop),
    .wdata (fifo_wd),
    .rdata (fifo_rd),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign head_id   = fifo_rd[EW-1 -: ID_W];
  assign head_addr = fifo_rd[ADDR_W:1];
  assign head_miss = fifo_rd[0];

  // Read data for a hit is the request address, fitted to DATA_W.
  generate
    if (DATA_W == ADDR_W) begin : g_dfit_eq
      assign hit_data = head_addr;
    end else if (DATA_W > ADDR_W) begin : g_dfit_ext
      assign hit_data = {{(DATA_W-ADDR_W){1'b0}}, head_addr};
    end else begin : g_dfit_trunc
      assign hit_data = head_addr[DATA_W-1:0];
    end
  endgenerate

  // State, latency counter and registered R channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lat_cnt  <= '0;
      alive    <= 1'b0;
      rvalid_q <= 1'b0;
      rid_q    <= '0;
      rdata_q  <= '0;
      rresp_q  <= '0;
      rlast_q  <= 1'b0;
    end else begin
      state    <= state_d;
      lat_cnt  <= lat_d;
      alive    <= 1'b1;
      rvalid_q <= rvalid_d;
      rid_q    <= rid_d;
      rdata_q  <= rdata_d;
      rresp_q  <= rresp_d;
      rlast_q  <= rlast_d;
    end
  end

  // Next state: wait out the latency on the head entry, then present it
  // until the master takes it.
  always_comb begin
    state_d  = state;
    lat_d    = lat_cnt;
    pop      = 1'b0;
    rvalid_d = rvalid_q;
    rid_d    = rid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    rlast_d  = rlast_q;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = WAIT;
          lat_d   = LAT_INIT;
        end
      end
      WAIT: begin
        if (lat_cnt == '0) begin
          state_d  = RESP;
          rvalid_d = 1'b1;
          rid_d    = head_id;
          rlast_d  = 1'b1;
          rresp_d  = head_miss ? RESP_DECERR : RESP_OKAY;
          rdata_d  = head_miss ? '0 : hit_data;
        end else begin
          lat_d = lat_cnt - 1'b1;
        end
      end
      RESP: begin
        if (axi_slv.rready) begin
          pop      = 1'b1;
          rvalid_d = 1'b0;
          rid_d    = '0;
          rdata_d  = '0;
          rresp_d  = '0;
          rlast_d  = 1'b0;
          // Count is pre-pop; a same-cycle push is picked up from IDLE.
          if (fifo_count > (PW+1)'(1)) begin
            state_d = WAIT;
            lat_d   = LAT_INIT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign axi_slv.arready = arready;
  assign axi_slv.rvalid  = rvalid_q;
  assign axi_slv.rid     = rid_q;
  assign axi_slv.rdata   = rdata_q;
  assign axi_slv.rresp   = rresp_q;
  assign axi_slv.rlast   = rlast_q;

endmodule

// File: tb/tb_easyaxi_slv_rd.sv
// Bench for easyaxi_slv_rd: vector table, hand sequences for corner cases,
// and random traffic checked against a queue-based response/timing model.
module tb_easyaxi_slv_rd;
  import easyaxi_pkg::*;

  localparam int          DEPTH  = 4;
  localparam int          RD_LAT = 2;
  localparam logic [31:0] BASE   = 32'h0000_0000;
  localparam logic [31:0] SPAN   = 32'h0000_1000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic enable = 1'b0;
  always #5 clk = ~clk;

  easyaxi_slv_rd_if #(.ID_W(4), .ADDR_W(32), .DATA_W(32)) bus();

  easyaxi_slv_rd #(
    .ID_W(4), .ADDR_W(32), .DATA_W(32), .DEPTH(DEPTH),
    .BASE_ADDR(BASE), .ADDR_SPAN(SPAN), .RD_LAT(RD_LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .enable  (enable),
    .axi_slv (bus)
  );

  typedef struct {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
  } exp_t;

  typedef struct {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
    int          exp_lat;
  } vec_t;

  vec_t        vecs[7];
  exp_t        q[$];
  logic [3:0]  got_ids[$];
  int          exp_rise = -1;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  logic        s_arready, s_rvalid, s_rlast;
  logic [3:0]  s_rid;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  int          s_cyc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  // Response a request should get, from the window rule alone.
  function automatic exp_t predict(input logic [3:0] id, input logic [31:0] addr);
    exp_t   e;
    longint a, lo, hi;
    a  = longint'(addr);
    lo = longint'(BASE);
    hi = longint'(BASE) + longint'(SPAN);
    e.id = id;
    if (a >= lo && a < hi) begin
      e.data = addr;
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b11;
    end
    return e;
  endfunction

  // One clock: sample at negedge, check against the model, advance the model
  // for the handshakes the coming edge will perform.
  task automatic tick();
    bit exp_arr, exp_rv, rhs, ahs;
    int e;
    @(negedge clk);
    s_arready = bus.arready;
    s_rvalid  = bus.rvalid;
    s_rid     = bus.rid;
    s_rdata   = bus.rdata;
    s_rresp   = bus.rresp;
    s_rlast   = bus.rlast;
    s_cyc     = cyc;
    exp_arr = enable && (q.size() < DEPTH);
    exp_rv  = (exp_rise >= 0) && (cyc >= exp_rise) && (q.size() > 0);
    chk("arready", 64'(s_arready), 64'(exp_arr));
    chk("rvalid", 64'(s_rvalid), 64'(exp_rv));
    if (exp_rv)
      chk("r_fields", {s_rid, s_rdata, s_rresp, s_rlast}, {q[0].id, q[0].data, q[0].resp, 1'b1});
    else
      chk("r_idle_zero", {s_rid, s_rdata, s_rresp, s_rlast}, 64'h0);
    e   = cyc + 1;
    rhs = exp_rv && bus.rready;
    ahs = bus.arvalid && exp_arr;
    if (rhs) begin
      got_ids.push_back(s_rid);
      void'(q.pop_front());
      exp_rise = (q.size() > 0) ? e + RD_LAT : -1;
    end
    if (ahs) begin
      if (q.size() == 0) exp_rise = e + 1 + RD_LAT;
      q.push_back(predict(bus.arid, bus.araddr));
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_rvalid(input string nm);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!s_rvalid && n < 20);
    if (!s_rvalid) chk(nm, 64'(s_rvalid), 64'h1);
  endtask

  task automatic drain();
    int n;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b1;
    n = 0;
    while ((q.size() > 0 || exp_rise >= 0) && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("drain_timeout", 64'(q.size()), 64'h0);
    tick();
  endtask

  // Asynchronous reset: outputs must clear without waiting for a clock edge.
  task automatic do_reset();
    bus.arvalid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_arready", 64'(bus.arready), 64'h0);
    chk("rst_rvalid", 64'(bus.rvalid), 64'h0);
    chk("rst_r_zero", {bus.rid, bus.rdata, bus.rresp, bus.rlast}, 64'h0);
    @(posedge clk); cyc++;
    @(posedge clk); cyc++;
    #3 rst_n = 1'b1;
    @(posedge clk); cyc++;
    #1;
    q.delete();
    exp_rise = -1;
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int acc;
    bus.rready  = 1'b1;
    bus.arvalid = 1'b1;
    bus.arid    = v.id;
    bus.araddr  = v.addr;
    tick();
    chk({nm, "_acc"}, 64'(s_arready), 64'h1);
    acc = s_cyc + 1;
    bus.arvalid = 1'b0;
    wait_rvalid({nm, "_timeout"});
    chk({nm, "_lat"}, 64'(s_cyc - acc), 64'(v.exp_lat));
    chk({nm, "_rid"}, 64'(s_rid), 64'(v.id));
    chk({nm, "_rdata"}, 64'(s_rdata), 64'(v.exp_data));
    chk({nm, "_rresp"}, 64'(s_rresp), 64'(v.exp_resp));
    chk({nm, "_rlast"}, 64'(s_rlast), 64'h1);
    drain();
  endtask

  initial begin
    int pop_cyc, n;
    vec_t v;
    vecs[0] = '{4'h3, 32'h0000_0010, 32'h0000_0010, 2'b00, 3};
    vecs[1] = '{4'h5, 32'h0000_1000, 32'h0000_0000, 2'b11, 3};
    vecs[2] = '{4'h1, 32'h0000_0FFF, 32'h0000_0FFF, 2'b00, 3};
    vecs[3] = '{4'h2, 32'h0000_0000, 32'h0000_0000, 2'b00, 3};
    vecs[4] = '{4'h7, 32'hFFFF_FFFF, 32'h0000_0000, 2'b11, 3};
    vecs[5] = '{4'hA, 32'h0000_0800, 32'h0000_0800, 2'b00, 3};
    vecs[6] = '{4'hF, 32'h0000_1001, 32'h0000_0000, 2'b11, 3};

    bus.arvalid = 1'b0;
    bus.arid    = '0;
    bus.araddr  = '0;
    bus.rready  = 1'b0;
    enable      = 1'b1;
    do_reset();
    tick();

    // Decode / latency vectors.
    for (int i = 0; i < 7; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Fill to full with rready low, then release and check ordering.
    got_ids.delete();
    bus.rready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.arvalid = 1'b1;
      bus.arid    = 4'(i);
      bus.araddr  = 32'(i * 16);
      tick();
      chk("fill_acc", 64'(s_arready), 64'h1);
    end
    bus.arid   = 4'h4;
    bus.araddr = 32'h40;
    tick();
    chk("full_arready", 64'(s_arready), 64'h0);
    wait_rvalid("full_rv_timeout");
    bus.rready = 1'b1;
    tick();
    chk("full_pop_no_bypass", 64'(s_arready), 64'h0);
    pop_cyc = s_cyc;
    tick();
    chk("full_rearm", 64'(s_arready), 64'h1);
    chk("full_rearm_cycle", 64'(s_cyc - pop_cyc), 64'h1);
    drain();
    chk("order_cnt", 64'(got_ids.size()), 64'h5);
    for (int i = 0; i < 5 && i < got_ids.size(); i++)
      chk("order_id", 64'(got_ids[i]), 64'(i));

    // R backpressure: response held for 6 cycles, popped only on handshake.
    bus.rready  = 1'b0;
    bus.arvalid = 1'b1;
    bus.arid    = 4'h6;
    bus.araddr  = 32'h20;
    tick();
    bus.arvalid = 1'b0;
    wait_rvalid("bp_timeout");
    v.id = s_rid; v.exp_data = s_rdata; v.exp_resp = s_rresp;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("bp_hold", {s_rvalid, s_rid, s_rdata, s_rresp}, {1'b1, 4'h6, 32'h20, 2'b00});
    end
    chk("bp_first", {v.id, v.exp_data, v.exp_resp}, {4'h6, 32'h20, 2'b00});
    drain();

    // enable low with two entries buffered and a request pending.
    got_ids.delete();
    bus.rready = 1'b0;
    bus.arvalid = 1'b1; bus.arid = 4'h8; bus.araddr = 32'h100;  tick();
    bus.arid = 4'h9;    bus.araddr = 32'h2000; tick();
    enable = 1'b0;
    bus.arid = 4'hC;    bus.araddr = 32'h30;
    tick();
    chk("en_low_arready", 64'(s_arready), 64'h0);
    bus.rready = 1'b1;
    n = 0;
    while (got_ids.size() < 2 && n < 40) begin tick(); n++; end
    chk("en_low_drained", 64'(got_ids.size()), 64'h2);
    enable = 1'b1;
    tick();
    chk("en_high_accept", 64'(s_arready), 64'h1);
    drain();
    chk("en_order", {got_ids[0], got_ids[1], got_ids[2]}, {4'h8, 4'h9, 4'hC});

    // Reset while presenting a response with three entries outstanding.
    bus.rready = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      bus.arvalid = 1'b1; bus.arid = 4'(i); bus.araddr = 32'(i * 4);
      tick();
    end
    bus.arvalid = 1'b0;
    wait_rvalid("rst_rv_timeout");
    do_reset();
    tick();
    chk("post_rst_rvalid", 64'(s_rvalid), 64'h0);
    run_vec(vecs[0], "post_rst");

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.arvalid = ($urandom_range(0, 1) == 1);
      bus.arid    = 4'($urandom);
      case ($urandom_range(0, 3))
        0: bus.araddr = 32'($urandom_range(0, 32'hFFF));
        1: bus.araddr = 32'h0000_0FFF;
        2: bus.araddr = 32'h0000_1000;
        default: bus.araddr = $urandom;
      endcase
      bus.rready = ($urandom_range(0, 9) < 6);
      enable     = ($urandom_range(0, 9) < 8);
      tick();
    end
    enable = 1'b1;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
